simplez_core_p: RTL

//  Parametrised Simplez CPU core: 3-bit opcode, AW-bit address, accumulator machine.

---
 rtl/simplez_mem_if.sv | 23 ++
 rtl/simplez_core_p.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/simplez_mem_if.sv
// rtl/simplez_mem_if.sv - Simplez memory request/ready bus
// The core is the master; RAM/ROM or a bus fabric sits on the slave side.
interface simplez_mem_if #(
  parameter int AW = 9,
  parameter int DW = 12
);
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/simplez_core_p.sv
// rtl/simplez_core_p.sv - Simplez accumulator CPU core with req/ready memory bus
// Define SIMPLEZ_IO_EN to map ST to the all-ones address onto the io_out_o register.
module simplez_core_p #(
  parameter int AW         = 9,
  parameter int DW         = 12,
  parameter int WAIT_DELAY = 2400000,
  parameter int RESET_PC   = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          run_i,
  simplez_mem_if.master mem,
  output logic [DW-1:0] acc_o,
  output logic          zflag_o,
  output logic [DW-1:0] io_out_o,
  output logic          busy_o,
  output logic          stop_o
);

`ifdef SIMPLEZ_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  localparam int CW = (WAIT_DELAY > 1) ? $clog2(WAIT_DELAY + 1) : 1;

  if (DW != AW + 3) begin : g_bad_width
    $error("simplez_core_p: DW must equal AW+3");
  end

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_EXEC1, S_EXEC2, S_END, S_HALT
  } state_t;

  localparam logic [2:0] OP_ST  = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_BR  = 3'd3;
  localparam logic [2:0] OP_BZ  = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] acc_q;
  logic          z_q;
  logic [DW-1:0] io_q;
  logic          stop_q;
  logic          re_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] opnd_q;
  logic [CW-1:0] wcnt_q;

  logic [2:0]    co, co_rd;
  logic [3:0]    coe;
  logic [AW-1:0] cd, cd_rd;
  logic          io_hit, io_hit_rd;
  logic [DW-1:0] acc_dec_d, acc_add_d;
  logic [AW-1:0] pc_inc_d;

  assign co        = ir_q[DW-1:DW-3];
  assign coe       = ir_q[DW-1:DW-4];
  assign cd        = ir_q[AW-1:0];
  assign co_rd     = mem.mem_rdata[DW-1:DW-3];
  assign cd_rd     = mem.mem_rdata[AW-1:0];
  assign io_hit    = IO_EN && (cd == {AW{1'b1}});
  assign io_hit_rd = IO_EN && (cd_rd == {AW{1'b1}});
  assign acc_dec_d = acc_q - DW'(1);
  assign acc_add_d = acc_q + opnd_q;
  assign pc_inc_d  = pc_q + AW'(1);

  // Requests for EXEC1 are raised on the FETCH->EXEC1 edge so re/we come straight from flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_INIT;
      pc_q    <= AW'(RESET_PC);
      ir_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      io_q    <= '0;
      stop_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      opnd_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (run_i) begin
            re_q    <= 1'b1;
            addr_q  <= pc_q;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem.mem_ready) begin
            ir_q    <= mem.mem_rdata;
            re_q    <= 1'b0;
            wcnt_q  <= '0;
            state_q <= S_EXEC1;
            if (co_rd == OP_ST && !io_hit_rd) begin
              we_q   <= 1'b1;
              addr_q <= cd_rd;
            end else if (co_rd == OP_LD || co_rd == OP_ADD) begin
              re_q   <= 1'b1;
              addr_q <= cd_rd;
            end
          end
        end
        S_EXEC1: begin
          unique case (co)
            OP_ST: begin
              if (io_hit) begin
                io_q    <= acc_q;
                state_q <= S_END;
              end else if (mem.mem_ready) begin
                we_q    <= 1'b0;
                state_q <= S_END;
              end
            end
            OP_LD, OP_ADD: begin
              if (mem.mem_ready) begin
                opnd_q  <= mem.mem_rdata;
                re_q    <= 1'b0;
                state_q <= S_EXEC2;
              end
            end
            OP_BR: begin
              pc_q    <= cd;
              state_q <= S_INIT;
            end
            OP_BZ: begin
              if (z_q) begin
                pc_q    <= cd;
                state_q <= S_INIT;
              end else begin
                state_q <= S_END;
              end
            end
            OP_CLR: begin
              acc_q   <= '0;
              z_q     <= 1'b1;
              state_q <= S_END;
            end
            OP_DEC: begin
              acc_q   <= acc_dec_d;
              z_q     <= (acc_dec_d == '0);
              state_q <= S_END;
            end
            default: begin
              if (coe == 4'hE) begin
                stop_q  <= 1'b1;
                state_q <= S_HALT;
              end else if (coe == 4'hF) begin
                if (wcnt_q == CW'(WAIT_DELAY - 1)) begin
                  state_q <= S_END;
                end else begin
                  wcnt_q <= wcnt_q + CW'(1);
                end
              end else begin
                state_q <= S_END;
              end
            end
          endcase
        end
        S_EXEC2: begin
          if (co == OP_LD) begin
            acc_q <= opnd_q;
            z_q   <= (opnd_q == '0);
          end else begin
            acc_q <= acc_add_d;
            z_q   <= (acc_add_d == '0);
          end
          state_q <= S_END;
        end
        S_END: begin
          pc_q    <= pc_inc_d;
          state_q <= S_INIT;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_re    = re_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = acc_q;

  assign acc_o    = acc_q;
  assign zflag_o  = z_q;
  assign io_out_o = IO_EN ? io_q : '0;
  assign busy_o   = (state_q != S_INIT);
  assign stop_o   = stop_q;

endmodule
